// File: rtl/systolic_pkg.sv
// ---------------------------------------------------------------------------
// systolic_pkg
//   Shared types and constants for the systolic MAC array sequencer.
//   Contents:
//     state_e  - sequencer states (IDLE, CLEAR, FEED, DRAIN, UNLOAD, DONE)
//     DW       - data width of one array result word (Q6.10)
//     FRAC     - number of fractional bits in the Q6.10 format
//     Q_ONE    - the value 1.0 in Q6.10
// ---------------------------------------------------------------------------
package systolic_pkg;

  localparam int DW   = 16;
  localparam int FRAC = 10;
  localparam logic [15:0] Q_ONE = 16'd1024;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    FEED   = 3'd2,
    DRAIN  = 3'd3,
    UNLOAD = 3'd4,
    DONE   = 3'd5
  } state_e;

endpackage

// File: rtl/systolic_seq_ctrl_counter.sv
// ---------------------------------------------------------------------------
// seq_counter
//   Loadable up-counter with terminal-count flag. Counts 0..last_i and wraps
//   back to 0 on the increment after last_i, so a counter that is enabled for
//   exactly last_i+1 cycles always ends at 0.
//   Ports:
//     clk        in   clock
//     reset      in   synchronous active-high reset (count -> 0)
//     load_i     in   load load_val_i (wins over en_i)
//     load_val_i in   value to load
//     en_i       in   increment enable
//     last_i     in   terminal value
//     count_o    out  current count
//     tc_o       out  high while count_o == last_i
// ---------------------------------------------------------------------------
module seq_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] last_i,
  output logic [WIDTH-1:0] count_o,
  output logic             tc_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next count: load has priority; an enabled increment at the terminal value
  // wraps to zero so the counter is ready for the next use.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (en_i) begin
      count_d = (count_q == last_i) ? '0 : count_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign tc_o    = (count_q == last_i);

endmodule

// File: rtl/systolic_seq_ctrl.sv
// ---------------------------------------------------------------------------
// systolic_seq_ctrl
//   Sequencer for the NxN output-stationary systolic MAC array (Q6.10).
//   One accepted start clears the array, feeds K = 0..N-1, waits for the
//   skewed pipeline to drain, snapshots all N*N accumulators and streams them
//   out row-major over a valid/ready interface.
//   Optional feature macro: SEQ_PERF_CNT_EN adds the perf_cycles port, a
//   saturating count of busy cycles of the most recent run.
//   Ports:
//     clk          in   clock
//     reset        in   synchronous active-high reset
//     start        in   run request, only sampled in IDLE
//     busy         out  high from CLEAR through DONE
//     done         out  one-cycle pulse in the last cycle of a run
//     arr_clr      out  accumulator clear to the array
//     mem_addr     out  operand-memory K address
//     feed_en      out  operand data valid
//     res_in       in   array accumulators, PE(i,j) at [(i*N+j)*DW +: DW]
//     res_valid    out  result word valid
//     res_ready    in   consumer accepts result word
//     res_data     out  result word
//     res_idx      out  result index i*N+j
//     perf_cycles  out  run length in cycles (SEQ_PERF_CNT_EN only)
// ---------------------------------------------------------------------------
module systolic_seq_ctrl #(
  parameter int N            = 3,
  parameter int DW           = systolic_pkg::DW,
  parameter int DRAIN_CYCLES = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic                   arr_clr,
  output logic [$clog2(N)-1:0]   mem_addr,
  output logic                   feed_en,
  input  logic [N*N*DW-1:0]      res_in,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [DW-1:0]          res_data,
  output logic [$clog2(N*N)-1:0] res_idx
`ifdef SEQ_PERF_CNT_EN
  ,
  output logic [15:0]            perf_cycles
`endif
);

  import systolic_pkg::*;

  localparam int AW = $clog2(N);
  localparam int IW = $clog2(N*N);
  localparam int CW = $clog2(DRAIN_CYCLES);

  state_e state_q, state_d;

  logic          start_acc;
  logic          k_en, drain_en, idx_en, cap_en;
  logic          k_tc, drain_tc, idx_tc;
  logic [AW-1:0] k_cnt;
  logic [CW-1:0] drain_cnt;
  logic [IW-1:0] idx_cnt;

  logic [DW-1:0] cap_q [N*N];

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and Moore-style control outputs. The counters move only while
  // their phase is active and wrap to zero when the phase ends, so every run
  // starts from clean counts without extra clearing logic.
  always_comb begin
    state_d   = state_q;
    busy      = 1'b1;
    done      = 1'b0;
    arr_clr   = 1'b0;
    feed_en   = 1'b0;
    res_valid = 1'b0;
    start_acc = 1'b0;
    k_en      = 1'b0;
    drain_en  = 1'b0;
    idx_en    = 1'b0;
    cap_en    = 1'b0;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          start_acc = 1'b1;
          state_d   = CLEAR;
        end
      end
      CLEAR: begin
        arr_clr = 1'b1;
        state_d = FEED;
      end
      FEED: begin
        feed_en = 1'b1;
        k_en    = 1'b1;
        if (k_tc) state_d = DRAIN;
      end
      DRAIN: begin
        drain_en = 1'b1;
        if (drain_tc) begin
          cap_en  = 1'b1;
          state_d = UNLOAD;
        end
      end
      UNLOAD: begin
        res_valid = 1'b1;
        if (res_ready) begin
          idx_en = 1'b1;
          if (idx_tc) state_d = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        busy    = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // K index of the operand memories during FEED.
  seq_counter #(.WIDTH(AW)) u_k_cnt (
    .clk        (clk),
    .reset      (reset),
    .load_i     (start_acc),
    .load_val_i ('0),
    .en_i       (k_en),
    .last_i     (AW'(N-1)),
    .count_o    (k_cnt),
    .tc_o       (k_tc)
  );

  // Pipeline drain wait after the last feed.
  seq_counter #(.WIDTH(CW)) u_drain_cnt (
    .clk        (clk),
    .reset      (reset),
    .load_i     (start_acc),
    .load_val_i ('0),
    .en_i       (drain_en),
    .last_i     (CW'(DRAIN_CYCLES-1)),
    .count_o    (drain_cnt),
    .tc_o       (drain_tc)
  );

  // Result word index; advances only on an accepted handshake.
  seq_counter #(.WIDTH(IW)) u_idx_cnt (
    .clk        (clk),
    .reset      (reset),
    .load_i     (start_acc),
    .load_val_i ('0),
    .en_i       (idx_en),
    .last_i     (IW'(N*N-1)),
    .count_o    (idx_cnt),
    .tc_o       (idx_tc)
  );

  // Snapshot of the array on the final drain cycle; after this the array may
  // be reused or cleared without disturbing the unload.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N*N; i++) cap_q[i] <= '0;
    end else if (cap_en) begin
      for (int i = 0; i < N*N; i++) cap_q[i] <= res_in[i*DW +: DW];
    end
  end

  assign mem_addr = feed_en   ? k_cnt          : '0;
  assign res_idx  = res_valid ? idx_cnt        : '0;
  assign res_data = res_valid ? cap_q[idx_cnt] : '0;

`ifdef SEQ_PERF_CNT_EN
  logic [15:0] perf_q, perf_d;

  // Busy-cycle counter: cleared on an accepted start, saturates, and holds
  // its final value while idle so the host can read it after done.
  always_comb begin
    perf_d = perf_q;
    if (start_acc) begin
      perf_d = '0;
    end else if (busy && (perf_q != 16'hFFFF)) begin
      perf_d = perf_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_q <= '0;
    end else begin
      perf_q <= perf_d;
    end
  end

  assign perf_cycles = perf_q;
`endif

endmodule
